// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared types and helpers for the memory bus arbiter.
//             - owner_t : who currently owns the single memory port.
//             - beat_cnt_width() : beat counter width, never below 1 bit.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_M = 2'd1,
        OWN_F = 2'd2
    } owner_t;

    // A 1-beat block still needs a 1-bit counter so the port width is legal.
    function automatic int beat_cnt_width(input int blocksize);
        if (blocksize <= 1) begin
            return 1;
        end
        return $clog2(blocksize);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_beat_counter
//  Purpose  : Beat counter for one locked burst. Wraps to 0 after
//             BLOCKSIZE-1 and flags the final beat of the block.
//  Ports    : clk, reset (async active-low)
//             clear   - synchronous clear on burst release
//             advance - one beat completed this cycle
//             count   - current beat index
//             last    - count is on the final beat of the block
//  Revision : 1.0  initial release
// ============================================================================
module mem_beat_counter
    import mem_bus_pkg::*;
#(
    parameter int BLOCKSIZE = 4,
    parameter int CW        = beat_cnt_width(BLOCKSIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] C_LAST_BEAT = CW'(BLOCKSIZE - 1);

    assign last = (count == C_LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Arbitrates the single memory port between the data cache (M)
//             and the instruction cache (F), locking the grant for a whole
//             block of BLOCKSIZE beats. Contention is resolved round-robin,
//             data-first out of reset.
//  Ports    : clk, reset (async active-low)
//             HRequestM/HWriteM/HAddrM/HWDataM -> BusReadyM   data cache side
//             HRequestF/HAddrF                 -> BusReadyF   instr cache side
//             HRData                                          shared read data
//             MemReq/MemWrite/MemAddr/MemWD <- MemRD/MemReady memory port
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int BLOCKSIZE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HRequestM,
    input  logic        HWriteM,
    input  logic [31:0] HAddrM,
    input  logic [31:0] HWDataM,
    output logic        BusReadyM,
    input  logic        HRequestF,
    input  logic [31:0] HAddrF,
    output logic        BusReadyF,
    output logic [31:0] HRData,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD,
    input  logic        MemReady
);

    localparam int CW = beat_cnt_width(BLOCKSIZE);

    owner_t          state;
    owner_t          state_nxt;
    logic            data_first;
    logic            data_first_nxt;
    logic            own_m;
    logic            own_f;
    logic            owner_req;
    logic            owner_ready;
    logic            release_burst;
    logic [CW-1:0]   beat_count;
    logic            beat_last;

    assign own_m = (state == OWN_M);
    assign own_f = (state == OWN_F);

    // Owner's request; a request held by the non-owner never reaches memory.
    assign owner_req   = (own_m & HRequestM) | (own_f & HRequestF);
    // MemReady is only meaningful while a beat is actually requested.
    assign owner_ready = MemReady & owner_req;

    // Release after the final beat, or when the owner walks away before any
    // beat completed. A drop mid-burst keeps ownership and just idles MemReq.
    assign release_burst = (state != IDLE) &&
                           ((beat_last && owner_ready) ||
                            (!owner_req && (beat_count == '0)));

    // ------------------------------------------------------------------------
    // Memory port and cache-side handshakes
    // ------------------------------------------------------------------------
    assign MemReq    = owner_req;
    assign MemWrite  = own_m & HWriteM;
    assign MemAddr   = own_m ? HAddrM : (own_f ? HAddrF : 32'h0);
    assign MemWD     = own_m ? HWDataM : 32'h0;
    assign BusReadyM = MemReady & own_m & HRequestM;
    assign BusReadyF = MemReady & own_f & HRequestF;
    assign HRData    = MemRD;

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        data_first_nxt = data_first;
        case (state)
            IDLE: begin
                if (HRequestM && HRequestF) begin
                    state_nxt      = data_first ? OWN_M : OWN_F;
                    // Hand the next contention to the side that lost this one.
                    data_first_nxt = !data_first;
                end else if (HRequestM) begin
                    state_nxt = OWN_M;
                end else if (HRequestF) begin
                    state_nxt = OWN_F;
                end
            end
            OWN_M, OWN_F: begin
                if (release_burst) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            data_first <= 1'b1;
        end else begin
            state      <= state_nxt;
            data_first <= data_first_nxt;
        end
    end

    mem_beat_counter #(
        .BLOCKSIZE (BLOCKSIZE),
        .CW        (CW)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (release_burst),
        .advance (owner_ready),
        .count   (beat_count),
        .last    (beat_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter. A behavioural model
//             (owner id, beats done, whose turn) predicts every output each
//             cycle; vector tables and hand sequences add fixed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int BS = 4;

    logic        clk;
    logic        reset;
    logic        HRequestM;
    logic        HWriteM;
    logic [31:0] HAddrM;
    logic [31:0] HWDataM;
    logic        BusReadyM;
    logic        HRequestF;
    logic [31:0] HAddrF;
    logic        BusReadyF;
    logic [31:0] HRData;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic [31:0] MemRD;
    logic        MemReady;

    mem_bus_arbiter #(.BLOCKSIZE(BS)) dut (
        .clk       (clk),
        .reset     (reset),
        .HRequestM (HRequestM),
        .HWriteM   (HWriteM),
        .HAddrM    (HAddrM),
        .HWDataM   (HWDataM),
        .BusReadyM (BusReadyM),
        .HRequestF (HRequestF),
        .HAddrF    (HAddrF),
        .BusReadyF (BusReadyF),
        .HRData    (HRData),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemWD     (MemWD),
        .MemRD     (MemRD),
        .MemReady  (MemReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: 0 = nobody, 1 = data cache, 2 = instruction cache.
    int owner  = 0;
    int beats  = 0;
    bit turn_m = 1'b1;

    // Outputs captured at the checking point of the last step().
    logic seen_req, seen_wr, seen_rm, seen_rf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_req();
        if (owner == 1) return HRequestM;
        if (owner == 2) return HRequestF;
        return 1'b0;
    endfunction

    task automatic model_reset();
        owner  = 0;
        beats  = 0;
        turn_m = 1'b1;
    endtask

    task automatic model_clock();
        logic r;
        r = model_req();
        if (owner == 0) begin
            beats = 0;
            if (HRequestM && HRequestF) begin
                owner  = turn_m ? 1 : 2;
                turn_m = !turn_m;
            end else if (HRequestM) begin
                owner = 1;
            end else if (HRequestF) begin
                owner = 2;
            end
        end else if (r && MemReady) begin
            beats = beats + 1;
            if (beats == BS) begin
                owner = 0;
                beats = 0;
            end
        end else if (!r && beats == 0) begin
            owner = 0;
        end
    endtask

    task automatic check_model();
        chk("MemReq",    {31'b0, MemReq},    {31'b0, model_req()});
        chk("MemWrite",  {31'b0, MemWrite},  {31'b0, (owner == 1) && HWriteM});
        chk("MemAddr",   MemAddr, (owner == 1) ? HAddrM : ((owner == 2) ? HAddrF : 32'h0));
        chk("MemWD",     MemWD,   (owner == 1) ? HWDataM : 32'h0);
        chk("BusReadyM", {31'b0, BusReadyM}, {31'b0, (owner == 1) && HRequestM && MemReady});
        chk("BusReadyF", {31'b0, BusReadyF}, {31'b0, (owner == 2) && HRequestF && MemReady});
        chk("HRData",    HRData, MemRD);
    endtask

    // Called at posedge+1; checks mid-cycle, then advances one clock.
    task automatic step();
        #3;
        check_model();
        seen_req = MemReq;
        seen_wr  = MemWrite;
        seen_rm  = BusReadyM;
        seen_rf  = BusReadyF;
        @(posedge clk);
        if (!reset) model_reset();
        else        model_clock();
        #1;
    endtask

    typedef struct {
        bit          rm, wm, rf, rdy;
        logic [31:0] addr;
        bit          e_req, e_wr, e_rm, e_rf;
    } vec_t;

    function automatic vec_t mk(input bit rm, input bit wm, input bit rf, input bit rdy,
                                input logic [31:0] addr,
                                input bit e_req, input bit e_wr, input bit e_rm, input bit e_rf);
        vec_t v;
        v.rm = rm; v.wm = wm; v.rf = rf; v.rdy = rdy; v.addr = addr;
        v.e_req = e_req; v.e_wr = e_wr; v.e_rm = e_rm; v.e_rf = e_rf;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, rel_k, wb, fb, rb;
        bit order_ok;

        reset = 1'b0; HRequestM = 0; HWriteM = 0; HAddrM = 0; HWDataM = 0;
        HRequestF = 0; HAddrF = 0; MemRD = 32'hA5A5_0000; MemReady = 0;
        seen_req = 0; seen_wr = 0; seen_rm = 0; seen_rf = 0;

        // Data-only write burst, then contention: M first, then F.
        vecs[0]  = mk(1,1,0,1, 32'h100, 0,0,0,0);
        vecs[1]  = mk(1,1,0,1, 32'h100, 1,1,1,0);
        vecs[2]  = mk(1,1,0,1, 32'h104, 1,1,1,0);
        vecs[3]  = mk(1,1,0,1, 32'h108, 1,1,1,0);
        vecs[4]  = mk(1,1,0,1, 32'h10C, 1,1,1,0);
        vecs[5]  = mk(0,0,0,0, 32'h0,   0,0,0,0);
        vecs[6]  = mk(1,0,1,1, 32'h200, 0,0,0,0);
        for (int i = 7; i <= 10; i++) vecs[i] = mk(1,0,1,1, 32'h200 + 32'(4*(i-7)), 1,0,1,0);
        vecs[11] = mk(1,0,1,1, 32'h300, 0,0,0,0);
        for (int i = 12; i <= 15; i++) vecs[i] = mk(1,0,1,1, 32'h300 + 32'(4*(i-12)), 1,0,0,1);
        vecs[16] = mk(0,0,0,0, 32'h0,   0,0,0,0);

        // Reset state.
        @(posedge clk); #1;
        step();
        chk("reset_MemReq", {31'b0, seen_req}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            HRequestM = vecs[i].rm; HWriteM = vecs[i].wm; HRequestF = vecs[i].rf;
            MemReady  = vecs[i].rdy;
            HAddrM    = vecs[i].addr;
            HAddrF    = vecs[i].addr | 32'h1000;
            HWDataM   = 32'hD000_0000 | 32'(i);
            MemRD     = 32'hC000_0000 | 32'(i);
            step();
            chk($sformatf("vec%0d_MemReq", i),    {31'b0, seen_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d_MemWrite", i),  {31'b0, seen_wr},  {31'b0, vecs[i].e_wr});
            chk($sformatf("vec%0d_BusReadyM", i), {31'b0, seen_rm},  {31'b0, vecs[i].e_rm});
            chk($sformatf("vec%0d_BusReadyF", i), {31'b0, seen_rf},  {31'b0, vecs[i].e_rf});
        end

        // Wait states: F burst with MemReady every third cycle.
        HRequestF = 1; HAddrF = 32'h4000;
        pulses = 0; rel_k = -1;
        for (int k = 0; k < 40; k++) begin
            MemReady = (k % 3 == 2);
            MemRD    = $urandom;
            step();
            if (seen_rf) pulses++;
            if (pulses == BS) begin
                rel_k = k;
                HRequestF = 0;
                break;
            end
        end
        MemReady = 0;
        chk("waitstate_pulses", 32'(pulses), 32'(BS));
        chk("waitstate_last_beat_cycle", 32'(rel_k), 32'd11);
        step();
        chk("waitstate_released", {31'b0, seen_req}, 32'h0);

        // Single/abandoned access: F granted, drops before any beat.
        HRequestF = 1;
        step();
        HRequestF = 0;
        step();
        HRequestM = 1; HWriteM = 1; HAddrM = 32'h500;
        step();
        chk("abandon_idle_gap", {31'b0, seen_req}, 32'h0);
        step();
        chk("abandon_then_M_granted", {31'b0, seen_req}, 32'h1);
        HRequestM = 0;
        step();
        step();

        // Async reset during beat 2 of an M burst.
        HRequestM = 1; HWriteM = 1; MemReady = 1;
        step();
        step();
        #1 reset = 1'b0;
        #1;
        chk("async_rst_MemReq",    {31'b0, MemReq},    32'h0);
        chk("async_rst_BusReadyM", {31'b0, BusReadyM}, 32'h0);
        model_reset();
        step();
        reset = 1'b1;
        HWriteM = 0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (seen_rm) pulses++;
            if (pulses == BS) HRequestM = 0;
        end
        chk("post_reset_full_burst", 32'(pulses), 32'(BS));

        // Writeback, then fill, with the instruction cache pending.
        HRequestM = 1; HWriteM = 1; HRequestF = 1; MemReady = 1;
        wb = 0; fb = 0; rb = 0; order_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            HAddrM = $urandom; HAddrF = $urandom; HWDataM = $urandom; MemRD = $urandom;
            step();
            if (seen_rm && seen_wr)  wb++;
            if (seen_rm && !seen_wr) begin
                rb++;
                if (fb < BS) order_ok = 1'b0;
            end
            if (seen_rf) begin
                fb++;
                if (wb < BS || rb > 0) order_ok = 1'b0;
            end
            if (wb == BS) HWriteM = 0;
            if (fb == BS) HRequestF = 0;
            if (rb == BS) begin
                HRequestM = 0;
                break;
            end
        end
        chk("wb_write_beats", 32'(wb), 32'(BS));
        chk("wb_fetch_beats", 32'(fb), 32'(BS));
        chk("wb_fill_beats",  32'(rb), 32'(BS));
        chk("wb_order",       {31'b0, order_ok}, 32'h1);
        step();

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if (owner == 1 && beats > 0) HRequestM = 1;
            else                         HRequestM = ($urandom % 4) != 0;
            if (owner != 1)              HWriteM = $urandom;
            if (owner == 2 && beats > 0) HRequestF = 1;
            else                         HRequestF = ($urandom % 4) != 0;
            HAddrM = $urandom; HAddrF = $urandom; HWDataM = $urandom; MemRD = $urandom;
            MemReady = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
